// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and default widths for the memory arbiter
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;
endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rtl/mem_arbiter_rr_pick.sv - two-way round-robin winner selection, one-hot result
module rr_pick (
  input  logic [1:0] req,
  input  logic       last_m1,
  output logic [1:0] pick
);
  always_comb begin
    pick = 2'b00;
    // On a tie the master that did not win last time gets the memory
    if (req[0] && req[1]) begin
      pick = last_m1 ? 2'b01 : 2'b10;
    end else if (req[0]) begin
      pick = 2'b01;
    end else if (req[1]) begin
      pick = 2'b10;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master single-port memory arbiter, IDLE/ACCESS/DONE per transaction
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_ack,
  output logic              m1_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  state_t            state, state_n;
  logic [1:0]        gnt, gnt_n;
  logic [1:0]        ack, ack_n;
  logic [1:0]        pick;
  logic              last_m1, last_m1_n;
  logic              lat_we, lat_we_n;
  logic              mem_we_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n;
  logic [DATA_W-1:0] rdata_n;

  rr_pick u_pick (
    .req     ({m1_req, m0_req}),
    .last_m1 (last_m1),
    .pick    (pick)
  );

  always_comb begin
    state_n     = state;
    gnt_n       = gnt;
    ack_n       = 2'b00;
    last_m1_n   = last_m1;
    lat_we_n    = lat_we;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    rdata_n     = rdata;
    case (state)
      IDLE: begin
        if (|pick) begin
          gnt_n       = pick;
          last_m1_n   = pick[1];
          lat_we_n    = pick[1] ? m1_we    : m0_we;
          mem_we_n    = pick[1] ? m1_we    : m0_we;
          mem_addr_n  = pick[1] ? m1_addr  : m0_addr;
          mem_wdata_n = pick[1] ? m1_wdata : m0_wdata;
          state_n     = ACCESS;
        end
      end
      ACCESS: begin
        mem_we_n = 1'b0;
        state_n  = DONE;
      end
      DONE: begin
        // mem_addr is still held, so mem_rdata reflects the granted address
        if (!lat_we) begin
          rdata_n = mem_rdata;
        end
        ack_n   = gnt;
        gnt_n   = 2'b00;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      gnt       <= 2'b00;
      ack       <= 2'b00;
      last_m1   <= 1'b1;
      lat_we    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      ack       <= ack_n;
      last_m1   <= last_m1_n;
      lat_we    <= lat_we_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      rdata     <= rdata_n;
    end
  end

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];
  assign m0_ack = ack[0];
  assign m1_ack = ack[1];
  assign busy   = (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural memory
module tb_mem_arbiter;
  logic       clk;
  logic       rst;
  logic       m0_req, m0_we, m1_req, m1_we;
  logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic       m0_gnt, m1_gnt, m0_ack, m1_ack;
  logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic       mem_we, busy;
  logic [7:0] mem [256];

  typedef struct {
    logic       m;
    logic [7:0] rd;
  } exp_t;
  exp_t exp_q[$];

  int compared = 0;
  int failed   = 0;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m0_gnt    (m0_gnt),
    .m1_gnt    (m1_gnt),
    .m0_ack    (m0_ack),
    .m1_ack    (m1_ack),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural memory: preload, then synchronous write, combinational read
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[3] = 8'hA5;
    mem[2] = 8'h11;
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m0_gnt || m1_gnt || m0_ack || m1_ack) begin
      compared++;
      if ((m0_gnt && m1_gnt) || (m0_ack && m1_ack)) begin
        failed++;
        $display("FAIL exclusive: gnt=%b%b ack=%b%b at %0t", m1_gnt, m0_gnt, m1_ack, m0_ack, $time);
      end
    end
    if (m0_ack || m1_ack) begin
      compared++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_ack: ack=%b%b with no transaction pending at %0t", m1_ack, m0_ack, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (m1_ack !== e.m || m0_ack !== !e.m || rdata !== e.rd) begin
          failed++;
          $display("FAIL ack_data: ack=%b%b rdata=0x%0h expected master %0d rdata=0x%0h at %0t",
                   m1_ack, m0_ack, rdata, e.m, e.rd, $time);
        end
      end
    end
  end

  task automatic drive(input logic m, input logic req, input logic we,
                       input logic [7:0] addr, input logic [7:0] wdata);
    if (m) begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end
  endtask

  task automatic txn(input logic m, input logic we, input logic [7:0] addr,
                     input logic [7:0] wdata, input logic [7:0] rd_exp, input logic keep);
    exp_t e;
    e.m = m; e.rd = rd_exp;
    exp_q.push_back(e);
    drive(m, 1'b1, we, addr, wdata);
    @(posedge clk); #1;
    check("gnt_after_edge", m ? m1_gnt : m0_gnt, 1);
    check("busy_access", busy, 1);
    check("mem_addr", mem_addr, addr);
    check("mem_we_access", mem_we, we);
    @(posedge clk); #1;
    check("mem_we_done", mem_we, 0);
    @(posedge clk); #1;
    check("ack_latency", m ? m1_ack : m0_ack, 1);
    if (!keep) drive(m, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    #2 rst = 1'b0;
    #1;
    check("rst_gnt", {m1_gnt, m0_gnt}, 0);
    check("rst_ack", {m1_ack, m0_ack}, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    @(negedge clk);
    rst = 1'b1;

    // m0 read of 0x03, then m1 write 0x5C to 0x07 (rdata untouched), then m0 readback
    txn(1'b0, 1'b0, 8'h03, 8'h00, 8'hA5, 1'b0);
    check("rdata_a5", rdata, 8'hA5);
    txn(1'b1, 1'b1, 8'h07, 8'h5C, 8'hA5, 1'b0);
    check("mem7_written", mem[7], 8'h5C);
    txn(1'b0, 1'b0, 8'h07, 8'h00, 8'h5C, 1'b0);

    // m1 twice back to back while m1 won last: no idle gap
    txn(1'b1, 1'b0, 8'h03, 8'h00, 8'hA5, 1'b1);
    txn(1'b1, 1'b0, 8'h07, 8'h00, 8'h5C, 1'b0);

    // m0 drops its request one cycle after grant; transaction still completes
    begin
      exp_t e;
      e.m = 1'b0; e.rd = 8'hA5;
      exp_q.push_back(e);
    end
    drive(1'b0, 1'b1, 1'b0, 8'h03, 8'h00);
    @(posedge clk); #1;
    check("drop_gnt", m0_gnt, 1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 8'h03, 8'h00);
    @(posedge clk); #1;
    check("drop_ack", m0_ack, 1);
    @(posedge clk); #1;
    check("drop_busy", busy, 0);
    check("drop_gnt_clear", m0_gnt, 0);
    check("drop_no_regrant", m1_gnt, 0);

    // reset, then both masters request continuously: m0, m1, m0, m1
    #1 rst = 1'b0;
    #1;
    check("rst2_rdata", rdata, 0);
    check("rst2_busy", busy, 0);
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      e.m = k[0];
      e.rd = k[0] ? 8'h5C : 8'hA5;
      exp_q.push_back(e);
    end
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 8'h03, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'h07, 8'h00);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("rr_gnt", {m1_gnt, m0_gnt}, k[0] ? 2 : 1);
      @(posedge clk);
      @(posedge clk); #1;
      check("rr_ack", {m1_ack, m0_ack}, k[0] ? 2 : 1);
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk); #1;

    // m0 write 0xFF to 0x02 aborted by reset during ACCESS
    drive(1'b0, 1'b1, 1'b1, 8'h02, 8'hFF);
    @(posedge clk); #1;
    check("abort_gnt", m0_gnt, 1);
    check("abort_mem_we_hi", mem_we, 1);
    #2 rst = 1'b0;
    #1;
    check("abort_mem_we_lo", mem_we, 0);
    check("abort_gnt_lo", m0_gnt, 0);
    check("abort_busy", busy, 0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_mem2", mem[2], 8'h11);
    check("abort_no_ack", {m1_ack, m0_ack}, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the width of every address port.
REQ-002 Parameter DATA_W, default 8, SHALL set the width of every data port.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 m0_req / m1_req  in  1  SHALL be the per-master access requests (m0 = CPU, m1 = second requester).
REQ-006 m0_we / m1_we  in  1  SHALL select write (1) or read (0).
REQ-007 m0_addr / m1_addr  in  ADDR_W  SHALL be the access addresses.
REQ-008 m0_wdata / m1_wdata  in  DATA_W  SHALL be the write data.
REQ-009 m0_gnt / m1_gnt  out  1  SHALL indicate which master currently owns the memory.
REQ-010 m0_ack / m1_ack  out  1  SHALL be one-cycle completion pulses.
REQ-011 rdata  out  DATA_W  SHALL hold the read data, shared by both masters and qualified by the ackX pulse.
REQ-012 mem_addr  out  ADDR_W, mem_we  out  1, mem_wdata  out  DATA_W  SHALL form the memory command.
REQ-013 mem_rdata  in  DATA_W  SHALL be the combinational read data from the memory.
REQ-014 busy  out  1  SHALL be high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have three states, IDLE, ACCESS and DONE, and no others.
REQ-016 IDLE: on an edge with any request high, the FSM SHALL pick the winner, set its gnt, latch the winner's addr/we/wdata onto mem_*, and go to ACCESS.
REQ-017 IDLE with no request high: the FSM SHALL hold all outputs and stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: with both requests high, the master that did not win last SHALL be granted.
REQ-019 A single requester SHALL win regardless of which master won last.
REQ-020 ACCESS: mem_we SHALL equal the latched we for exactly this one cycle; the next edge SHALL clear mem_we and go to DONE.
REQ-021 DONE: the next edge SHALL load rdata from mem_rdata (reads only; rdata unchanged on writes), pulse the winner's ack for one cycle, clear gnt, and go to IDLE.
REQ-022 Latency: req sampled high at edge N SHALL give gnt high after N, ack high after N+2 for one cycle, and the next grant no earlier than edge N+3.
REQ-023 Masters SHALL hold req, we, addr and wdata stable from request until ack; the arbiter SHALL use only the values latched at grant.
REQ-024 A request still high in the ack cycle SHALL be re-arbitrated as a new transaction.
REQ-025 A request dropped after grant SHALL NOT abort the transaction; it still completes with ack.
REQ-026 At most one gnt and at most one ack SHALL be high in any cycle.
REQ-027 Addresses SHALL pass through unmodified; the arbiter SHALL perform no wrap-around.

Reset
REQ-028 rst low SHALL immediately, independent of clk, force: state IDLE; gnt, ack, mem_we and busy to 0; mem_addr, mem_wdata and rdata to 0; last-winner to m1, so that m0 wins the first tie.
REQ-029 Reset asserted during ACCESS SHALL drop mem_we at once, abort the write, and produce no ack.
REQ-030 After rst deasserts, the first arbitration SHALL occur on the first rising edge with rst high.

Structure
REQ-031 Package mem_arb_pkg SHALL hold the state encoding (IDLE=0, ACCESS=1, DONE=2, 2 bits) and the default widths.
REQ-032 The combinational winner selection (two requests plus last-winner in; one-hot grant out) SHALL be the sub-module rr_pick.
REQ-033 The memory port SHALL use unidirectional buses; tristate conversion to an inout memory happens at top level.

Verification
REQ-034 Reset, then m0 read of 0x03 with memory[3]=0xA5: m0_gnt rises after edge 1, m0_ack pulses after edge 3, rdata=0xA5.
REQ-035 m1 write of 0x5C to 0x07: mem_we high for exactly one cycle with mem_addr=0x07; a later m0 read of 0x07 returns 0x5C.
REQ-036 Both masters request continuously after reset: grants alternate m0, m1, m0, m1, one per 3 cycles, and gnt/ack are never both-masters high.
REQ-037 rst pulled low mid-ACCESS of an m0 write of 0xFF to 0x02: mem_we falls without a clock; no ack; memory[2] unchanged.
REQ-038 m0 drops req one cycle after grant: m0_ack still pulses; FSM returns to IDLE; busy=0.
REQ-039 m1 alone requests after m1 won last: m1 is granted with no idle gap.
